// File: rtl/uv_pkg.sv
// rtl/uv_pkg.sv - shared constants and FSM encoding for the ultrasonic echo emulator
package uv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } uv_state_e;

  localparam int MIN_TRIG_CYCLES_DEF    = 500;
  localparam int BURST_DELAY_CYCLES_DEF = 25000;
  localparam int MAX_ECHO_CYCLES_DEF    = 1900000;
  localparam int HOLDOFF_CYCLES_DEF     = 50000;
  localparam int RESET_WIDTH            = 18000;

  // Shared with the fault/pick detector so both sides agree on the same windows.
  localparam int FAULT_WIN_LO = 17000;
  localparam int FAULT_WIN_HI = 19000;
  localparam int PICK_WIN_LO  = 7000;
  localparam int PICK_WIN_HI  = 9000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with synchronous active-high reset
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uv_echo_emulator.sv
// rtl/uv_echo_emulator.sv - HC-SR04-style responder: validates trigger width, answers with a programmed echo pulse
module uv_echo_emulator
  import uv_pkg::*;
#(
  parameter int MIN_TRIG_CYCLES    = MIN_TRIG_CYCLES_DEF,
  parameter int BURST_DELAY_CYCLES = BURST_DELAY_CYCLES_DEF,
  parameter int MAX_ECHO_CYCLES    = MAX_ECHO_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES     = HOLDOFF_CYCLES_DEF,
  parameter int WIDTH_W            = 21
) (
  input  logic               clk_50M,
  input  logic               reset,
  input  logic               UV_trig,
  input  logic [WIDTH_W-1:0] echo_width,
  input  logic               width_load,
  input  logic               object_present,
  output logic               UV_echo,
  output logic               busy,
  output logic               trig_error,
  output logic [7:0]         meas_count
);

  localparam logic [WIDTH_W-1:0] ZERO_W  = '0;
  localparam logic [WIDTH_W-1:0] ONE_W   = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] MAX_W   = WIDTH_W'(MAX_ECHO_CYCLES);
  localparam logic [WIDTH_W-1:0] RESET_W = WIDTH_W'(RESET_WIDTH);
  localparam logic [WIDTH_W-1:0] BURST_W = WIDTH_W'(BURST_DELAY_CYCLES);
  localparam logic [WIDTH_W-1:0] HOLD_W  = WIDTH_W'(HOLDOFF_CYCLES);
  // Trigger width is counted down from MIN-1; reaching zero means the pulse was long enough.
  localparam logic [WIDTH_W-1:0] TRIG_W  = WIDTH_W'(MIN_TRIG_CYCLES - 1);

  logic               trig_s;
  uv_state_e          state, state_next;
  logic [WIDTH_W-1:0] cnt, cnt_next;
  logic [WIDTH_W-1:0] width_reg, shadow;
  logic               echo_next, err_next, echo_done, capture;

  sync_2ff u_sync (
    .clk   (clk_50M),
    .reset (reset),
    .d     (UV_trig),
    .q     (trig_s)
  );

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      width_reg <= RESET_W;
    end else if (width_load) begin
      if (echo_width == ZERO_W)
        width_reg <= ONE_W;
      else if (echo_width > MAX_W)
        width_reg <= MAX_W;
      else
        width_reg <= echo_width;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    echo_next  = UV_echo;
    err_next   = 1'b0;
    echo_done  = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig_s) begin
          state_next = S_TRIG;
          cnt_next   = TRIG_W;
        end
      end
      S_TRIG: begin
        if (trig_s) begin
          if (cnt != ZERO_W)
            cnt_next = cnt - ONE_W;
        end else if (cnt == ZERO_W) begin
          state_next = S_BURST;
          cnt_next   = BURST_W;
          capture    = 1'b1;
        end else begin
          state_next = S_IDLE;
          cnt_next   = ZERO_W;
          err_next   = 1'b1;
        end
      end
      S_BURST: begin
        if (cnt <= ONE_W) begin
          state_next = S_ECHO;
          cnt_next   = shadow;
          echo_next  = 1'b1;
        end else begin
          cnt_next = cnt - ONE_W;
        end
      end
      S_ECHO: begin
        if (cnt <= ONE_W) begin
          state_next = S_HOLDOFF;
          cnt_next   = HOLD_W;
          echo_next  = 1'b0;
          echo_done  = 1'b1;
        end else begin
          cnt_next = cnt - ONE_W;
        end
      end
      S_HOLDOFF: begin
        if (cnt <= ONE_W) begin
          // A trigger already high as dead time expires starts counting right away.
          if (trig_s) begin
            state_next = S_TRIG;
            cnt_next   = TRIG_W;
          end else begin
            state_next = S_IDLE;
            cnt_next   = ZERO_W;
          end
        end else begin
          cnt_next = cnt - ONE_W;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = ZERO_W;
        echo_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= ZERO_W;
      shadow     <= ZERO_W;
      UV_echo    <= 1'b0;
      trig_error <= 1'b0;
      meas_count <= 8'd0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      UV_echo    <= echo_next;
      trig_error <= err_next;
      if (capture)
        shadow <= object_present ? width_reg : MAX_W;
      if (echo_done)
        meas_count <= meas_count + 8'd1;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uv_echo_emulator.sv
// tb/tb_uv_echo_emulator.sv - self-checking bench for uv_echo_emulator with scaled timing parameters
module tb_uv_echo_emulator;

  localparam int MIN  = 8;
  localparam int BD   = 40;
  localparam int MAXE = 300;
  localparam int HOLD = 50;
  localparam int WW   = 15;

  logic          clk_50M = 1'b0;
  logic          reset;
  logic          UV_trig;
  logic [WW-1:0] echo_width;
  logic          width_load;
  logic          object_present;
  logic          UV_echo;
  logic          busy;
  logic          trig_error;
  logic [7:0]    meas_count;

  uv_echo_emulator #(
    .MIN_TRIG_CYCLES    (MIN),
    .BURST_DELAY_CYCLES (BD),
    .MAX_ECHO_CYCLES    (MAXE),
    .HOLDOFF_CYCLES     (HOLD),
    .WIDTH_W            (WW)
  ) dut (
    .clk_50M        (clk_50M),
    .reset          (reset),
    .UV_trig        (UV_trig),
    .echo_width     (echo_width),
    .width_load     (width_load),
    .object_present (object_present),
    .UV_echo        (UV_echo),
    .busy           (busy),
    .trig_error     (trig_error),
    .meas_count     (meas_count)
  );

  always #5 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observed events, all stamped with the edge index after which they became visible.
  int rise_q[$];
  int fall_q[$];
  int err_cnt = 0;
  int busy_fall = 0;
  bit echo_prev = 1'b0;
  bit busy_prev = 1'b0;

  always @(negedge clk_50M) begin
    if (reset) begin
      echo_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (UV_echo && !echo_prev) rise_q.push_back(cyc);
      if (!UV_echo && echo_prev) fall_q.push_back(cyc);
      if (trig_error) err_cnt++;
      if (!busy && busy_prev) busy_fall = cyc;
      echo_prev = UV_echo;
      busy_prev = busy;
    end
  end

  // Reference model: width register contents and completed-echo count.
  int model_w;
  int model_meas;

  function automatic int clamp_width(input int v);
    if (v == 0) return 1;
    if (v > MAXE) return MAXE;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_width(input int v);
    @(negedge clk_50M);
    echo_width = WW'(v);
    width_load = 1'b1;
    @(negedge clk_50M);
    width_load = 1'b0;
    model_w = clamp_width(v);
  endtask

  task automatic run_trig(input int len, input bit obj, output int t_fall);
    @(negedge clk_50M);
    object_present = obj;
    UV_trig = 1'b1;
    repeat (len) @(negedge clk_50M);
    UV_trig = 1'b0;
    t_fall = cyc + 1;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50M);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still high after %0d cycles", tag, limit);
    end
    repeat (2) @(negedge clk_50M);
  endtask

  task automatic wait_echo(input int limit, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50M);
      if (UV_echo) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_echo_timeout: no echo within %0d cycles", tag, limit);
    end
  endtask

  // One full trigger transaction compared against the expected outcome.
  task automatic apply(input int len, input bit obj, input bit exp_acc, input int exp_w, input string tag);
    int t, r0, e0, rise, fall;
    r0 = rise_q.size();
    e0 = err_cnt;
    run_trig(len, obj, t);
    wait_idle(exp_acc ? BD + exp_w + HOLD + 50 : 50, tag);
    if (exp_acc) begin
      model_meas = (model_meas + 1) % 256;
      chk({tag, "_nrise"}, rise_q.size() - r0, 1);
      if (rise_q.size() > r0 && fall_q.size() > 0) begin
        rise = rise_q[rise_q.size() - 1];
        fall = fall_q[fall_q.size() - 1];
        chk({tag, "_rise"}, rise, t + 2 + BD);
        chk({tag, "_width"}, fall - rise, exp_w);
        chk({tag, "_busyfall"}, busy_fall, fall + HOLD);
      end
      chk({tag, "_err"}, err_cnt - e0, 0);
    end else begin
      chk({tag, "_nrise"}, rise_q.size() - r0, 0);
      chk({tag, "_err"}, err_cnt - e0, 1);
    end
    chk({tag, "_meas"}, int'(meas_count), model_meas);
    chk({tag, "_echo_low"}, int'(UV_echo), 0);
  endtask

  typedef struct {
    int len;
    bit obj;
    bit load_en;
    int load_val;
    bit exp_acc;
    int exp_w;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int t, r0, e0, m0, len, v, ew;
    bit obj, acc;

    vecs[0] = '{8,  1'b1, 1'b1, 200,  1'b1, 200};
    vecs[1] = '{7,  1'b1, 1'b0, 0,    1'b0, 0};
    vecs[2] = '{12, 1'b0, 1'b0, 0,    1'b1, 300};
    vecs[3] = '{9,  1'b1, 1'b1, 0,    1'b1, 1};
    vecs[4] = '{10, 1'b1, 1'b1, 5000, 1'b1, 300};
    vecs[5] = '{8,  1'b1, 1'b1, 301,  1'b1, 300};
    vecs[6] = '{3,  1'b1, 1'b1, 42,   1'b0, 0};
    vecs[7] = '{8,  1'b1, 1'b0, 0,    1'b1, 42};
    vecs[8] = '{20, 1'b0, 1'b1, 7,    1'b1, 300};
    vecs[9] = '{8,  1'b1, 1'b0, 0,    1'b1, 7};

    reset = 1'b1;
    UV_trig = 1'b0;
    echo_width = '0;
    width_load = 1'b0;
    object_present = 1'b1;
    model_w = 18000;
    model_meas = 0;
    repeat (3) @(negedge clk_50M);
    chk("rst_echo", int'(UV_echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(trig_error), 0);
    chk("rst_meas", int'(meas_count), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_50M);

    // Reset-value width register drives the first echo.
    apply(MIN, 1'b1, 1'b1, 18000, "rstwidth");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].load_en) load_width(vecs[i].load_val);
      apply(vecs[i].len, vecs[i].obj, vecs[i].exp_acc, vecs[i].exp_w, $sformatf("vec%0d", i));
    end

    // Reload during ECHO affects only the next echo.
    load_width(100);
    r0 = rise_q.size();
    run_trig(MIN, 1'b1, t);
    wait_echo(BD + 20, "midload");
    load_width(250);
    wait_idle(BD + 100 + HOLD + 50, "midload");
    model_meas = (model_meas + 1) % 256;
    chk("midload_nrise", rise_q.size() - r0, 1);
    if (rise_q.size() > r0)
      chk("midload_width", fall_q[fall_q.size() - 1] - rise_q[rise_q.size() - 1], 100);
    chk("midload_meas", int'(meas_count), model_meas);
    apply(MIN, 1'b1, 1'b1, 250, "nextload");

    // Trigger during HOLDOFF is ignored.
    load_width(20);
    r0 = rise_q.size();
    e0 = err_cnt;
    m0 = fall_q.size();
    run_trig(MIN, 1'b1, t);
    for (int i = 0; i < BD + 60 && fall_q.size() == m0; i++) @(negedge clk_50M);
    chk("hold_fell", fall_q.size() - m0, 1);
    run_trig(10, 1'b1, t);
    wait_idle(200, "hold");
    model_meas = (model_meas + 1) % 256;
    repeat (10) @(negedge clk_50M);
    chk("hold_nrise", rise_q.size() - r0, 1);
    chk("hold_err", err_cnt - e0, 0);
    chk("hold_meas", int'(meas_count), model_meas);
    chk("hold_busy", int'(busy), 0);

    // Reset in the middle of an echo.
    load_width(200);
    run_trig(MIN, 1'b1, t);
    wait_echo(BD + 20, "rstmid");
    repeat (5) @(negedge clk_50M);
    reset = 1'b1;
    @(negedge clk_50M);
    chk("rstmid_echo", int'(UV_echo), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_meas", int'(meas_count), 0);
    reset = 1'b0;
    model_meas = 0;
    model_w = 18000;
    repeat (3) @(negedge clk_50M);

    // Randomized transactions against the model.
    for (int i = 0; i < 30; i++) begin
      len = $urandom_range(MIN + 5, MIN - 3);
      obj = ($urandom_range(3, 0) != 0);
      if ($urandom_range(1, 0) == 1 || model_w > MAXE) begin
        v = $urandom_range(MAXE + 60, 0);
        if ($urandom_range(7, 0) == 0) v = 0;
        load_width(v);
      end
      acc = (len >= MIN);
      ew = obj ? model_w : MAXE;
      apply(len, obj, acc, ew, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
